// File: rtl/flash_pixel_unpacker_if.sv
// Bundle between the SPI flash reader, the pixel unpacker and the SPI LCD writer.
// The master view belongs to the unpacker; the slave view to the surrounding fabric.
interface flash_pixel_unpacker_if;
  logic [255:0] f_dataBuffer;
  logic         f_dataAvailable;
  logic         f_readyToRead;
  logic [15:0]  px_data;
  logic         px_valid;
  logic         px_ready;
  logic         px_sof;
  logic         px_eof;

  modport master (
    input  f_dataBuffer, f_dataAvailable, px_ready,
    output f_readyToRead, px_data, px_valid, px_sof, px_eof
  );

  modport slave (
    output f_dataBuffer, f_dataAvailable, px_ready,
    input  f_readyToRead, px_data, px_valid, px_sof, px_eof
  );
endinterface

// File: rtl/flash_pixel_unpacker.sv
// Captures 32-byte flash blocks and replays them as 16 RGB565 pixels with
// frame start/end markers driven by a free-running frame pixel counter.
module flash_pixel_unpacker #(
  parameter int FRAME_PIXELS = 76800,
  parameter int PIX_CNT_W    = 17,
  parameter int SWAP_BYTES   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  flash_pixel_unpacker_if.master  bus,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ACK, STREAM} state_t;

  localparam logic [PIX_CNT_W-1:0] LAST = PIX_CNT_W'(FRAME_PIXELS - 1);

  state_t                 state_q, state_d;
  logic [255:0]           hold_q, hold_d;
  logic                   rtr_q, rtr_d;
  logic                   vld_q, vld_d;
  logic [15:0]            data_q, data_d;
  logic [3:0]             pix_q, pix_d;
  logic [PIX_CNT_W-1:0]   frame_q, frame_d;
  logic                   xfer;

  // Flash stores pixels big-endian unless SWAP_BYTES is set.
  function automatic logic [15:0] pixel(input logic [255:0] h, input logic [3:0] k);
    logic [15:0] p;
    p = h[{k, 4'b0000} +: 16];
    if (SWAP_BYTES != 0) return p;
    else                 return {p[7:0], p[15:8]};
  endfunction

  assign xfer = vld_q & bus.px_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rtr_d   = 1'b0;
    vld_d   = vld_q;
    data_d  = data_q;
    pix_d   = pix_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (bus.f_dataAvailable) begin
          hold_d  = bus.f_dataBuffer;
          rtr_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        data_d  = pixel(hold_q, 4'd0);
        vld_d   = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (xfer) begin
          frame_d = (frame_q == LAST) ? '0 : frame_q + PIX_CNT_W'(1);
          pix_d   = pix_q + 4'd1;
          if (pix_q == 4'd15) begin
            vld_d   = 1'b0;
            state_d = IDLE;
          end else begin
            data_d  = pixel(hold_q, pix_q + 4'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rtr_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      pix_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rtr_q   <= rtr_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      pix_q   <= pix_d;
      frame_q <= frame_d;
    end
  end

  // Markers are gated by valid so they read low whenever no pixel is offered.
  assign bus.f_readyToRead = rtr_q;
  assign bus.px_valid      = vld_q;
  assign bus.px_data       = data_q;
  assign bus.px_sof        = vld_q & (frame_q == '0);
  assign bus.px_eof        = vld_q & (frame_q == LAST);
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_flash_pixel_unpacker.sv
// Scoreboard bench: two unpackers (normal and byte-swapped) share one flash/LCD
// stimulus; expected pixels are queued on issue and popped on each transfer.
module tb_flash_pixel_unpacker;
  localparam int FP = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flash_pixel_unpacker_if if0();
  flash_pixel_unpacker_if if1();
  logic busy0, busy1;

  assign if1.f_dataBuffer    = if0.f_dataBuffer;
  assign if1.f_dataAvailable = if0.f_dataAvailable;
  assign if1.px_ready        = if0.px_ready;

  flash_pixel_unpacker #(.FRAME_PIXELS(FP), .PIX_CNT_W(17), .SWAP_BYTES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .busy(busy0));
  flash_pixel_unpacker #(.FRAME_PIXELS(FP), .PIX_CNT_W(17), .SWAP_BYTES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1));

  typedef struct { logic [15:0] d0; logic [15:0] d1; logic sof; logic eof; } exp_t;
  exp_t q[$];

  int total = 0, bad = 0;
  int xfers = 0, acks = 0, ncyc = 0, last_xfer_cyc = 0, gap = 0;
  int mcnt = 0;
  logic toggle_mode = 1'b0, ready_lvl = 1'b1;
  logic pv = 1'b0, pr = 1'b0, prtr = 1'b0;
  logic [15:0] pd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] mkblk(input logic [7:0] base);
    logic [255:0] b;
    for (int n = 0; n < 32; n++) b[8*n +: 8] = base + 8'(n);
    return b;
  endfunction

  task automatic push_block(input logic [7:0] base);
    exp_t e;
    logic [7:0] b0, b1;
    for (int k = 0; k < 16; k++) begin
      b0 = base + 8'(2*k);
      b1 = base + 8'(2*k + 1);
      e.d0 = {b0, b1};
      e.d1 = {b1, b0};
      e.sof = (mcnt == 0);
      e.eof = (mcnt == FP - 1);
      mcnt = (mcnt == FP - 1) ? 0 : mcnt + 1;
      q.push_back(e);
    end
  endtask

  // Flash reader model: holds dataAvailable until acknowledged; with n>1 the
  // next block is presented straight after the ack so DA never drops.
  task automatic send_blocks(input int n, input logic [7:0] base0);
    int to;
    logic [7:0] b;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      b = base0 + 8'(64*i);
      if0.f_dataBuffer = mkblk(b);
      if0.f_dataAvailable = 1'b1;
      push_block(b);
      to = 0;
      do begin @(negedge clk); to++; end while (!if0.f_readyToRead && to < 200);
      if (to >= 200) chk("ack_timeout", 0, 1);
      @(posedge clk); #1;
    end
    if0.f_dataAvailable = 1'b0;
  endtask

  task automatic drain();
    int to = 0;
    while ((q.size() != 0 || busy0) && to < 1000) begin @(negedge clk); to++; end
    if (to >= 1000) chk("drain_timeout", 0, 1);
    chk("queue_empty", q.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if0.px_ready = toggle_mode ? ~if0.px_ready : ready_lvl;
  end

  // Monitor: scoreboard pops, hold stability, ack width, lockstep of both DUTs.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; prtr = 1'b0;
    end else begin
      if (if0.f_readyToRead) begin
        acks++;
        chk("ack_width", prtr, 0);
      end
      if (if1.px_valid !== if0.px_valid) chk("lockstep_valid", if1.px_valid, if0.px_valid);
      if (pv && !pr) begin
        chk("hold_valid", if0.px_valid, 1);
        chk("hold_data", if0.px_data, pd);
      end
      if (if0.px_valid && !pv) gap = ncyc - last_xfer_cyc;
      if (if0.px_valid && if0.px_ready) begin
        if (q.size() == 0) chk("unexpected_pixel", 1, 0);
        else begin
          e = q.pop_front();
          chk("px_data", if0.px_data, e.d0);
          chk("px_data_swap", if1.px_data, e.d1);
          chk("px_sof", if0.px_sof, e.sof);
          chk("px_eof", if0.px_eof, e.eof);
        end
        xfers++;
        last_xfer_cyc = ncyc;
      end
      pv = if0.px_valid; pr = if0.px_ready; pd = if0.px_data; prtr = if0.f_readyToRead;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, x0, to;
    if0.f_dataBuffer = '0;
    if0.f_dataAvailable = 1'b0;
    if0.px_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", if0.px_valid, 0);
    chk("rst_rtr", if0.f_readyToRead, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_data", if0.px_data, 0);
    chk("rst_sof", if0.px_sof, 0);
    chk("rst_eof", if0.px_eof, 0);
    chk("rst_valid_swap", if1.px_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic block with latency checks
    @(posedge clk); #1;
    if0.f_dataBuffer = mkblk(8'h00);
    if0.f_dataAvailable = 1'b1;
    push_block(8'h00);
    @(negedge clk);
    chk("lat_rtr_idle", if0.f_readyToRead, 0);
    chk("lat_valid_idle", if0.px_valid, 0);
    @(negedge clk);
    chk("lat_rtr_ack", if0.f_readyToRead, 1);
    chk("lat_valid_ack", if0.px_valid, 0);
    chk("lat_busy_ack", busy0, 1);
    @(posedge clk); #1 if0.f_dataAvailable = 1'b0;
    @(negedge clk);
    chk("lat_rtr_stream", if0.f_readyToRead, 0);
    chk("lat_valid_stream", if0.px_valid, 1);
    chk("first_px", if0.px_data, 16'h0001);
    chk("first_px_swap", if1.px_data, 16'h0100);
    chk("first_sof", if0.px_sof, 1);
    drain();
    chk("idle_busy", busy0, 0);

    // Ready toggling backpressure
    toggle_mode = 1'b1;
    send_blocks(1, 8'h00);
    drain();
    toggle_mode = 1'b0;

    // Back-to-back blocks with DA held high
    a0 = acks;
    send_blocks(2, 8'h10);
    drain();
    chk("b2b_acks", acks - a0, 2);
    chk("b2b_gap", gap, 3);

    // Reset after pixel 5
    send_blocks(1, 8'h21);
    x0 = xfers;
    to = 0;
    while (xfers < x0 + 6 && to < 200) begin @(posedge clk); to++; end
    if (to >= 200) chk("rst_wait_timeout", 0, 1);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    mcnt = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_xfers", xfers - x0, 6);
    chk("midrst_valid", if0.px_valid, 0);
    chk("midrst_busy", busy0, 0);
    chk("midrst_valid_swap", if1.px_valid, 0);

    // Frame of 20 pixels across three blocks, starting fresh after reset
    a0 = acks;
    send_blocks(3, 8'h33);
    drain();
    chk("frame_acks", acks - a0, 3);

    repeat (3) @(negedge clk);
    chk("end_rtr", if0.f_readyToRead, 0);
    chk("end_valid", if0.px_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flash_pixel_unpacker.md
Name: flash_pixel_unpacker

Overview:
- Sits directly downstream of the SPI flash reader, which delivers 32-byte blocks over a dataAvailable/readyToRead handshake.
- Captures each 256-bit block, acknowledges it, and streams it out as 16 RGB565 pixels over a valid/ready interface to the SPI LCD writer.
- Tracks the pixel position within a frame and flags the first and last pixel of each frame.

Parameters:
- FRAME_PIXELS, 76800: pixels per frame (320x240). Legal range is 1..2^PIX_CNT_W.
- PIX_CNT_W, 17: width of the frame pixel counter.
- SWAP_BYTES, 0: 0 means pixel k = {byte 2k, byte 2k+1} (big-endian in flash). 1 means pixel k = {byte 2k+1, byte 2k}.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- f_dataBuffer  in  256  block from flash reader; byte n = bits [8n+7:8n]
- f_dataAvailable  in  1  flash block valid
- f_readyToRead  out  1  one-cycle acknowledge pulse to flash reader
- px_data  out  16  pixel value
- px_valid  out  1  pixel valid
- px_ready  in  1  LCD writer accepts pixel
- px_sof  out  1  qualifies px_data as pixel 0 of a frame
- px_eof  out  1  qualifies px_data as pixel FRAME_PIXELS-1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at posedge) forces state=IDLE, f_readyToRead=0, px_valid=0, px_data=0, px_sof=0, px_eof=0, busy=0, pix_idx=0, frame_cnt=0. Reset mid-stream discards the held block.
- The flash reader has no reset. A block still pending with f_dataAvailable=1 is captured normally after reset release.
- States:
  - IDLE: if f_dataAvailable=1, latch f_dataBuffer into hold_reg, set f_readyToRead=1 and go to ACK. Otherwise stay.
  - ACK: f_readyToRead=1 for exactly this one cycle. f_dataAvailable is ignored here because it is still high; the flash reader drops it the following cycle. Load px_data from pixel 0 of hold_reg, set px_valid=1, go to STREAM.
  - STREAM: f_readyToRead=0 and f_dataAvailable is ignored.
    - A transfer occurs when px_valid & px_ready at the posedge. On a transfer, frame_cnt increments and pix_idx increments.
    - If pix_idx was 15, set px_valid=0 and go to IDLE. Otherwise present the next pixel the next cycle.
    - px_valid stays high and px_data/px_sof/px_eof stay stable until the transfer occurs.
- Latency:
  - f_dataAvailable rising in IDLE to first px_valid: 2 cycles.
  - With px_ready held high, 16 pixels take 16 consecutive cycles, then 1 IDLE cycle before the next capture. Block period is at least 18 cycles.
- Pixel extraction: with SWAP_BYTES=0, pixel k = {hold_reg[16k+7:16k], hold_reg[16k+15:16k+8]}.
- Frame tracking:
  - px_sof = (frame_cnt==0).
  - px_eof = (frame_cnt==FRAME_PIXELS-1).
  - On transfer of the eof pixel, frame_cnt wraps to 0.
  - frame_cnt is independent of block boundaries. If FRAME_PIXELS is not a multiple of 16, eof lands mid-block and the next pixel in the same block carries sof.
- FRAME_PIXELS=1: px_sof and px_eof are both high on every pixel.
- px_ready high while px_valid=0 has no effect.
- f_dataAvailable pulses that arrive while busy are not lost. The flash reader holds dataAvailable until acknowledged, so they are captured on return to IDLE.
- Exactly one f_readyToRead pulse is produced per captured block. f_readyToRead is never high in IDLE or STREAM.

Test Plan:
- Reset, then block with byte n = n, SWAP_BYTES=0, px_ready=1 -> f_readyToRead pulses 1 cycle exactly 1 cycle after DA seen. Pixels are 0x0001, 0x0203, ... 0x1E1F on 16 consecutive cycles. Then IDLE.
- Same block with px_ready toggling 1,0,1,0 -> each pixel held stable while ready=0. 16 transfers total, order unchanged, no duplicates.
- DA held high through the whole stream (back-to-back blocks A, B) -> exactly one acknowledge per block. B's first pixel appears 2 cycles after A's 16th transfer.
- FRAME_PIXELS=20, stream 3 blocks -> sof on pixels 0 and 20, eof on pixel 19 (block 1 index 3). Counter wraps correctly across block boundaries.
- Assert rst_n=0 for 1 cycle after pixel 5 of a block -> px_valid=0 next cycle, frame_cnt=0. The next captured block starts at pixel 0 with sof=1.
- SWAP_BYTES=1 with byte n = n -> pixel 0 = 0x0100, pixel 15 = 0x1F1E.
